// File: rtl/rom_addr_seq.sv
// rom_addr_seq: ROM address sequencer with a prescaled step rate.
// Ports: clk, rst (async high), en, sync, div_in, div_load ->
//   addr, addr_valid, wrap, div_pending, running.
// Optional macro ROM_ADDR_SEQ_DIR_EN adds input dir (1 = count down).
module rom_addr_seq #(
  parameter int ADDR_W = 8,
  parameter int DIV_W = 16,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
`ifdef ROM_ADDR_SEQ_DIR_EN
  input  logic              dir,
`endif
  input  logic [DIV_W-1:0]  div_in,
  input  logic              div_load,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              wrap,
  output logic              div_pending,
  output logic              running
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  div_act_q;
  logic [DIV_W-1:0]  shadow_q;
  logic              pend_q;
  logic              valid_q;
  logic              wrap_q;
  logic              run_q;

  logic active;
  logic step;
  logic at_end;
  logic wrap_step;

  assign active = (state_q != S_IDLE);
  // sync wins over a step landing in the same cycle
  assign step = active && (cnt_q == div_act_q) && !sync;

`ifdef ROM_ADDR_SEQ_DIR_EN
  assign at_end = dir ? (addr_q == '0) : (addr_q == '1);
  assign addr_d = dir ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
`else
  assign at_end = (addr_q == '1);
  assign addr_d = addr_q + ADDR_W'(1);
`endif

  assign wrap_step = step && at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      div_act_q <= DIV_RST;
      shadow_q  <= DIV_RST;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      valid_q <= step;
      wrap_q  <= wrap_step;

      if (sync) begin
        addr_q <= '0;
        cnt_q  <= '0;
      end else if (!active) begin
        cnt_q <= '0;
      end else if (step) begin
        cnt_q  <= '0;
        addr_q <= addr_d;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end

      // Divisor only changes when no period is in flight:
      // at a wrap step (count restarts) or while idle.
      if (div_load && wrap_step) begin
        div_act_q <= div_in;
        shadow_q  <= div_in;
        pend_q    <= 1'b0;
      end else if (div_load) begin
        shadow_q <= div_in;
        pend_q   <= 1'b1;
      end else if (pend_q && (wrap_step || !active)) begin
        div_act_q <= shadow_q;
        pend_q    <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          if (en) begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
          end
        end
        S_RUN: begin
          if (!en) state_q <= S_STOP;
        end
        S_STOP: begin
          if (sync || wrap_step) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
          end else if (en) begin
            state_q <= S_RUN;
          end
        end
        default: begin
          state_q <= S_IDLE;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign addr        = addr_q;
  assign addr_valid  = valid_q;
  assign wrap        = wrap_q;
  assign div_pending = pend_q;
  assign running     = run_q;

endmodule

// File: tb/tb_rom_addr_seq.sv
// tb_rom_addr_seq: directed vector table plus hand sequences
// for rom_addr_seq with default parameters.
module tb_rom_addr_seq;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sync;
  logic        dir;
  logic [15:0] div_in;
  logic        div_load;
  logic [7:0]  addr;
  logic        addr_valid;
  logic        wrap;
  logic        div_pending;
  logic        running;

  int checks = 0;
  int errors = 0;

  rom_addr_seq dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sync(sync),
`ifdef ROM_ADDR_SEQ_DIR_EN
    .dir(dir),
`endif
    .div_in(div_in),
    .div_load(div_load),
    .addr(addr),
    .addr_valid(addr_valid),
    .wrap(wrap),
    .div_pending(div_pending),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       sync;
    logic       ld;
    logic [15:0] din;
    logic [7:0] a;
    logic       v;
    logic       w;
    logic       p;
    logic       r;
  } vec_t;

  vec_t tv[15];

  function automatic vec_t mk(input logic r_, input logic e_,
      input logic s_, input logic l_, input logic [15:0] d_,
      input logic [7:0] a_, input logic v_, input logic w_,
      input logic p_, input logic run_);
    vec_t t;
    t.rst = r_; t.en = e_; t.sync = s_; t.ld = l_; t.din = d_;
    t.a = a_; t.v = v_; t.w = w_; t.p = p_; t.r = run_;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [7:0] a,
      input logic v, input logic w, input logic p, input logic r);
    chk({nm, ".addr"}, 32'(addr), 32'(a));
    chk({nm, ".valid"}, 32'(addr_valid), 32'(v));
    chk({nm, ".wrap"}, 32'(wrap), 32'(w));
    chk({nm, ".pend"}, 32'(div_pending), 32'(p));
    chk({nm, ".run"}, 32'(running), 32'(r));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ea;
  int guard;

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; dir = 1'b0;
    div_in = '0; div_load = 1'b0;

    tv[0]  = mk(1,0,0,0,0, 0,0,0,0,0);
    tv[1]  = mk(0,0,0,1,2, 0,0,0,1,0);
    tv[2]  = mk(0,0,0,0,0, 0,0,0,0,0);
    tv[3]  = mk(0,1,0,0,0, 0,0,0,0,1);
    tv[4]  = mk(0,1,0,0,0, 0,0,0,0,1);
    tv[5]  = mk(0,1,0,0,0, 0,0,0,0,1);
    tv[6]  = mk(0,1,0,0,0, 1,1,0,0,1);
    tv[7]  = mk(0,1,0,0,0, 1,0,0,0,1);
    tv[8]  = mk(0,1,1,0,0, 0,0,0,0,1);
    tv[9]  = mk(0,1,0,1,5, 0,0,0,1,1);
    tv[10] = mk(0,1,0,0,0, 0,0,0,1,1);
    tv[11] = mk(0,1,0,0,0, 1,1,0,1,1);
    tv[12] = mk(0,0,0,0,0, 1,0,0,1,1);
    tv[13] = mk(0,0,1,0,0, 0,0,0,1,0);
    tv[14] = mk(0,0,0,0,0, 0,0,0,0,0);

    #1;
    for (int i = 0; i < 15; i++) begin
      rst = tv[i].rst; en = tv[i].en; sync = tv[i].sync;
      div_load = tv[i].ld; div_in = tv[i].din;
      tick();
      chk_out($sformatf("vec%0d", i), tv[i].a, tv[i].v,
              tv[i].w, tv[i].p, tv[i].r);
    end
    sync = 1'b0; div_load = 1'b0;

    // full-speed run through one wrap
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1;
    tick();
    chk_out("run_entry", 8'd0, 0, 0, 0, 1);
    ea = 8'd0;
    for (int i = 0; i < 260; i++) begin
      tick();
      ea = ea + 8'd1;
      chk($sformatf("run%0d.addr", i), 32'(addr), 32'(ea));
      chk($sformatf("run%0d.valid", i), 32'(addr_valid), 32'd1);
      chk($sformatf("run%0d.wrap", i), 32'(wrap), 32'(ea == 8'd0));
    end

    // shadow divisor waits for the wrap
    div_load = 1'b1; div_in = 16'd3;
    tick();
    div_load = 1'b0;
    ea = ea + 8'd1;
    chk_out("ld3", ea, 1, 0, 1, 1);
    while (ea != 8'd0) begin
      tick();
      ea = ea + 8'd1;
      chk_out($sformatf("ld3_a%0d", ea), ea, 1, ea == 8'd0,
              ea != 8'd0, 1);
    end
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        chk_out($sformatf("div4_p%0d_c%0d", k, j), ea, 0, 0, 0, 1);
      end
      tick();
      ea = ea + 8'd1;
      chk_out($sformatf("div4_p%0d_step", k), ea, 1, 0, 0, 1);
    end

    // asynchronous reset between edges at addr 200
    guard = 0;
    while (addr != 8'd200 && guard < 2000) begin
      tick();
      guard++;
    end
    chk("reach200", 32'(addr), 32'd200);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 8'd0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    chk_out("rst_rel_run", 8'd0, 0, 0, 0, 1);
    tick();
    chk_out("rst_rel_step", 8'd1, 1, 0, 0, 1);
    ea = 8'd1;

    // stop request at addr 100 finishes the pass
    while (ea != 8'd100) begin
      tick();
      ea = ea + 8'd1;
      chk("to100", 32'(addr), 32'(ea));
    end
    en = 1'b0;
    tick();
    ea = ea + 8'd1;
    chk_out("stop_first", ea, 1, 0, 0, 1);
    while (ea != 8'd0) begin
      tick();
      ea = ea + 8'd1;
      chk_out($sformatf("stop_a%0d", ea), ea, 1, ea == 8'd0, 0,
              ea != 8'd0);
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      chk_out($sformatf("idle%0d", j), 8'd0, 0, 0, 0, 0);
    end

    // sync at addr 37
    en = 1'b1;
    tick();
    chk_out("rerun", 8'd0, 0, 0, 0, 1);
    ea = 8'd0;
    while (ea != 8'd37) begin
      tick();
      ea = ea + 8'd1;
    end
    chk("at37", 32'(addr), 32'd37);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk_out("sync", 8'd0, 0, 0, 0, 1);
    tick();
    chk_out("sync_next", 8'd1, 1, 0, 0, 1);
    ea = 8'd1;

    // divisor load landing on the wrap step
    while (ea != 8'd255) begin
      tick();
      ea = ea + 8'd1;
    end
    chk("at255", 32'(addr), 32'd255);
    div_load = 1'b1; div_in = 16'd2;
    tick();
    div_load = 1'b0;
    chk_out("ld_wrap", 8'd0, 1, 1, 0, 1);
    tick();
    chk_out("ldw_c0", 8'd0, 0, 0, 0, 1);
    tick();
    chk_out("ldw_c1", 8'd0, 0, 0, 0, 1);
    tick();
    chk_out("ldw_step", 8'd1, 1, 0, 0, 1);

`ifdef ROM_ADDR_SEQ_DIR_EN
    rst = 1'b1; dir = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_out("dn_entry", 8'd0, 0, 0, 0, 1);
    tick();
    chk_out("dn_wrap", 8'd255, 1, 1, 0, 1);
    tick();
    chk_out("dn_254", 8'd254, 1, 0, 0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_addr_seq.md
ROM_ADDR_SEQ -- requirements
Module: rom_addr_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning ROM address width.
REQ-002 The block SHALL have parameter DIV_W, default 16, meaning prescaler divisor width.
REQ-003 The block SHALL have parameter DIV_RST, default 0, meaning active divisor value after reset.
REQ-004 The block SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port en  input  1  run request, level-sensitive.
REQ-007 The block SHALL have port sync  input  1  single-cycle pulse that restarts the address sequence at 0.
REQ-008 The block SHALL have port div_in  input  DIV_W  new divisor: clk cycles per address step minus one.
REQ-009 The block SHALL have port div_load  input  1  single-cycle strobe capturing div_in into the shadow register.
REQ-010 The block SHALL have port addr  output  ADDR_W  registered ROM address, driven straight into the ROM addr input.
REQ-011 The block SHALL have port addr_valid  output  1  one-cycle pulse in the cycle addr holds a newly advanced value.
REQ-012 The block SHALL have port wrap  output  1  one-cycle pulse coincident with addr_valid when addr advanced from its end value to its start value.
REQ-013 The block SHALL have port div_pending  output  1  high while a shadow divisor awaits transfer to the active divisor.
REQ-014 The block SHALL have port running  output  1  high in states RUN and STOPPING.

Function
REQ-015 The block SHALL implement states IDLE, RUN, STOPPING; IDLE->RUN when en=1; RUN->STOPPING when en=0; STOPPING->RUN when en=1 before wrap; STOPPING->IDLE on the wrap step, or on sync.
REQ-016 In IDLE, addr SHALL hold, prescaler count SHALL hold at 0, and addr_valid and wrap SHALL stay 0.
REQ-017 In RUN/STOPPING the prescaler SHALL count 0..div_act; in the cycle count equals div_act, count SHALL return to 0 and addr SHALL advance on the same edge, giving one step every div_act+1 cycles (div_act=0: step every cycle).
REQ-018 The first step after IDLE->RUN SHALL occur div_act+1 cycles after the first RUN cycle.
REQ-019 addr SHALL increment modulo 2**ADDR_W; 2**ADDR_W-1 -> 0 SHALL assert wrap.
REQ-020 div_load SHALL write div_in to the shadow register and set div_pending; a later div_load before transfer SHALL overwrite the shadow.
REQ-021 The shadow SHALL transfer to div_act, clearing div_pending, on the next wrap step, or on the cycle after div_load when in IDLE.
REQ-022 div_load coinciding with a wrap step SHALL load div_in directly into div_act and leave div_pending 0.
REQ-023 A div_act change SHALL never alter the length of the step period in progress.
REQ-024 sync SHALL, with priority over stepping, set addr=0 and count=0 on the next edge without asserting addr_valid or wrap; in STOPPING it SHALL also force IDLE; div_pending and the shadow SHALL be unaffected.
REQ-025 A step and sync in the same cycle SHALL resolve as sync only.
REQ-026 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-027 On rst=1, without waiting for clk, the block SHALL set state=IDLE, addr=0, count=0, div_act=DIV_RST, shadow=DIV_RST, addr_valid=0, wrap=0, div_pending=0, running=0.
REQ-028 Reset asserted mid-operation SHALL abandon the current period; after release the block SHALL resume only per REQ-015 and REQ-018.

Configuration
REQ-029 With macro ROM_ADDR_SEQ_DIR_EN defined, the block SHALL add port dir  input  1, sampled at each step: dir=1 decrements addr modulo 2**ADDR_W, wrap asserting on 0 -> 2**ADDR_W-1; dir=0 behaves per REQ-019.
REQ-030 Without ROM_ADDR_SEQ_DIR_EN, port dir SHALL be absent and addr SHALL only increment.

Verification
REQ-031 Reset, en=1, div_act=0 for 260 cycles -> addr 1,2,...,255,0,1... one step per cycle; wrap high exactly on the cycle addr=0 after 255.
REQ-032 div_load div_in=3 mid-period in RUN -> div_pending=1; steps stay 1-cycle until wrap, then every 4 cycles; div_pending clears on wrap cycle.
REQ-033 en dropped at addr=100 with div_act=0 -> STOPPING, steps continue to 255->0, then IDLE with addr=0, running=0, no further addr_valid.
REQ-034 sync pulse at addr=37 in RUN -> next cycle addr=0, no wrap, no addr_valid; next step at addr=1 after div_act+1 cycles.
REQ-035 rst asserted asynchronously between edges at addr=200 -> addr=0 and all flags 0 before the next clk edge; en held 1 -> first step div_act+1 cycles after release.
REQ-036 With ROM_ADDR_SEQ_DIR_EN, dir=1 from reset, div_act=0 -> addr 255,254,...; wrap on the 0->255 step.
